// File: rtl/nabp_filtered_ram_pkg.sv
// rtl/nabp_filtered_ram_pkg.sv - shared types and latency helper for the filtered RAM fill scheduler
package nabp_filtered_ram_pkg;

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, IN_USE} bank_state_t;
  typedef enum logic [2:0] {IDLE, REQ, CLEAR, SWEEP, COMMIT} fill_state_t;

  // Cycles between presenting an s-address to the host RAM and its filtered sample appearing.
  function automatic int fill_latency(input int lookup_lat, input int filter_delay);
    return lookup_lat + filter_delay;
  endfunction

endpackage

// File: rtl/nabp_fill_sweep_counter.sv
// rtl/nabp_fill_sweep_counter.sv - per-angle sweep counter: host lookup address and latency-shifted write strobe
module nabp_fill_sweep_counter
  import nabp_filtered_ram_pkg::*;
#(
  parameter int S_W          = 9,
  parameter int LINE_SIZE    = 256,
  parameter int FILTER_DELAY = 4,
  parameter int LOOKUP_LAT   = 1
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic           run,
  output logic [S_W-1:0] hs_s_val,
  output logic           fill_we,
  output logic [S_W-1:0] fill_addr,
  output logic           last
);

  localparam int           LAT    = fill_latency(LOOKUP_LAT, FILTER_DELAY);
  localparam logic [S_W:0] LAT_K  = (S_W+1)'(LAT);
  localparam logic [S_W:0] LAST_K = (S_W+1)'(LINE_SIZE + LAT - 1);
  localparam logic [S_W:0] MAX_S  = (S_W+1)'(LINE_SIZE - 1);

  logic [S_W:0] k;

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      k <= '0;
    end else if (start) begin
      k <= '0;
    end else if (run && (k != LAST_K)) begin
      k <= k + 1'b1;
    end
  end

  // Addresses clamp at the line end while the pipeline drains its last samples.
  always_comb begin
    hs_s_val  = '0;
    fill_we   = 1'b0;
    fill_addr = '0;
    last      = 1'b0;
    if (run) begin
      hs_s_val = (k > MAX_S) ? S_W'(MAX_S) : S_W'(k);
      fill_we  = (k >= LAT_K);
      last     = (k == LAST_K);
      if (k >= LAT_K) begin
        fill_addr = S_W'(k - LAT_K);
      end
    end
  end

endmodule

// File: rtl/nabp_filtered_ram_fill_scheduler.sv
// rtl/nabp_filtered_ram_fill_scheduler.sv - fills the double-buffered filtered RAM one angle per bank
module nabp_filtered_ram_fill_scheduler
  import nabp_filtered_ram_pkg::*;
#(
  parameter int ANGLE_W      = 9,
  parameter int S_W          = 9,
  parameter int LINE_SIZE    = 256,
  parameter int FILTER_DELAY = 4,
  parameter int LOOKUP_LAT   = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [ANGLE_W-1:0] hs_angle,
  input  logic               hs_has_next_angle,
  input  logic               hs_next_angle_ack,
  output logic               hs_next_angle,
  output logic [S_W-1:0]     hs_s_val,
  output logic               filter_clear,
  output logic               filter_enable,
  output logic               fill_we,
  output logic               fill_bank,
  output logic [S_W-1:0]     fill_addr,
  input  logic               pr_next_angle,
  output logic               pr_next_angle_ack,
  output logic [ANGLE_W-1:0] pr_angle,
  output logic               pr_bank,
  output logic               done
);

  fill_state_t        state, state_nx;
  bank_state_t        bank_q [2];
  bank_state_t        bank_nx [2];
  logic [ANGLE_W-1:0] angle_q [2];
  logic [ANGLE_W-1:0] pr_angle_q;
  logic               pr_bank_q;
  logic               target, last_commit, last_seen;
  logic               req_open, req_done, done_q;
  logic               sweep_last, has_full, both_full, any_in_use, oldest;
  logic               new_req, grant, done_set;

  nabp_fill_sweep_counter #(
    .S_W         (S_W),
    .LINE_SIZE   (LINE_SIZE),
    .FILTER_DELAY(FILTER_DELAY),
    .LOOKUP_LAT  (LOOKUP_LAT)
  ) u_sweep (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (state == CLEAR),
    .run      (state == SWEEP),
    .hs_s_val (hs_s_val),
    .fill_we  (fill_we),
    .fill_addr(fill_addr),
    .last     (sweep_last)
  );

  always_comb begin
    state_nx      = state;
    hs_next_angle = 1'b0;
    filter_clear  = 1'b0;
    case (state)
      IDLE:   if ((bank_q[target] == EMPTY) && !last_seen) state_nx = REQ;
      REQ: begin
        hs_next_angle = 1'b1;
        if (hs_next_angle_ack) state_nx = CLEAR;
      end
      CLEAR: begin
        filter_clear = 1'b1;
        state_nx     = SWEEP;
      end
      SWEEP:  if (sweep_last) state_nx = COMMIT;
      COMMIT: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign filter_enable = (state == SWEEP);
  assign fill_bank     = (state == SWEEP) & target;

  // With both banks full, the older one is the bank not committed last.
  assign both_full  = (bank_q[0] == FULL) && (bank_q[1] == FULL);
  assign has_full   = (bank_q[0] == FULL) || (bank_q[1] == FULL);
  assign any_in_use = (bank_q[0] == IN_USE) || (bank_q[1] == IN_USE);
  assign oldest     = both_full ? ~last_commit : (bank_q[1] == FULL);
  assign new_req    = pr_next_angle && !req_open && !req_done;
  assign grant      = pr_next_angle && !req_done && has_full;
  assign done_set   = new_req && last_seen && (state == IDLE) && !has_full && any_in_use;

  assign pr_next_angle_ack = grant;
  assign pr_angle          = grant ? angle_q[oldest] : pr_angle_q;
  assign pr_bank           = grant ? oldest : pr_bank_q;
  assign done              = done_q;

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bank_nx[b] = bank_q[b];
      if (new_req && (bank_q[b] == IN_USE)) bank_nx[b] = EMPTY;
      if (grant && (oldest == 1'(b)))       bank_nx[b] = IN_USE;
      if ((state == CLEAR) && (target == 1'(b)))  bank_nx[b] = FILLING;
      if ((state == COMMIT) && (target == 1'(b))) bank_nx[b] = FULL;
    end
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state       <= IDLE;
      bank_q[0]   <= EMPTY;
      bank_q[1]   <= EMPTY;
      angle_q[0]  <= '0;
      angle_q[1]  <= '0;
      target      <= 1'b0;
      last_commit <= 1'b0;
      last_seen   <= 1'b0;
      req_open    <= 1'b0;
      req_done    <= 1'b0;
      done_q      <= 1'b0;
      pr_angle_q  <= '0;
      pr_bank_q   <= 1'b0;
    end else begin
      state  <= state_nx;
      bank_q <= bank_nx;
      if ((state == REQ) && hs_next_angle_ack) begin
        angle_q[target] <= hs_angle;
        last_seen       <= ~hs_has_next_angle;
      end
      if (state == COMMIT) begin
        target      <= ~target;
        last_commit <= target;
      end
      if (grant) begin
        pr_angle_q <= angle_q[oldest];
        pr_bank_q  <= oldest;
      end
      // One release+grant per rising request; a held level waits for deassertion.
      if (!pr_next_angle) begin
        req_open <= 1'b0;
        req_done <= 1'b0;
      end else if (grant) begin
        req_open <= 1'b0;
        req_done <= 1'b1;
      end else if (new_req) begin
        req_open <= 1'b1;
      end
      if (done_set) done_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_nabp_filtered_ram_fill_scheduler.sv
// tb/tb_nabp_filtered_ram_fill_scheduler.sv - scoreboard bench for the filtered RAM fill scheduler
module tb_nabp_filtered_ram_fill_scheduler;

  localparam int ANGLE_W = 9;
  localparam int S_W     = 9;

  logic               clk = 1'b0;
  logic               reset_n;
  logic [ANGLE_W-1:0] hs_angle;
  logic               hs_has_next_angle, hs_next_angle_ack, hs_next_angle;
  logic [S_W-1:0]     hs_s_val, fill_addr;
  logic               filter_clear, filter_enable, fill_we, fill_bank;
  logic               pr_next_angle, pr_next_angle_ack, pr_bank, done;
  logic [ANGLE_W-1:0] pr_angle;

  always #5 clk = ~clk;

  nabp_filtered_ram_fill_scheduler #(
    .ANGLE_W(ANGLE_W), .S_W(S_W), .LINE_SIZE(8), .FILTER_DELAY(2), .LOOKUP_LAT(1)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .hs_angle(hs_angle), .hs_has_next_angle(hs_has_next_angle),
    .hs_next_angle_ack(hs_next_angle_ack), .hs_next_angle(hs_next_angle),
    .hs_s_val(hs_s_val), .filter_clear(filter_clear), .filter_enable(filter_enable),
    .fill_we(fill_we), .fill_bank(fill_bank), .fill_addr(fill_addr),
    .pr_next_angle(pr_next_angle), .pr_next_angle_ack(pr_next_angle_ack),
    .pr_angle(pr_angle), .pr_bank(pr_bank), .done(done)
  );

  typedef struct packed {
    logic [8:0] angle;
    logic       has_next;
    logic [7:0] req_cycles;
  } host_t;

  host_t      host_q[$];
  logic [9:0] sweep_q[$];
  logic [9:0] fill_q[$];
  logic [9:0] grant_q[$];
  logic [8:0] sval_tab [11];
  logic [10:0] we_tab;
  logic [9:0] mon_e;

  int total = 0, bad = 0, cyc = 0, host_cnt = 0;
  int clear_cnt, rise_cnt, hi_len, third_rise_cyc, last_rise_cyc;
  int last_fill_cyc, last_ack_cyc, ack_gap;
  logic hs_prev;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic fail_unexpected(input string name);
    total++;
    bad++;
    $display("FAIL %s: output with empty expectation queue", name);
  endtask

  function automatic logic [63:0] out_vec();
    return 64'({hs_next_angle, hs_s_val, filter_clear, filter_enable, fill_we, fill_bank,
                fill_addr, pr_next_angle_ack, pr_angle, pr_bank, done});
  endfunction

  task automatic push_angle(input logic [8:0] a, input logic b, input logic hn, input logic [7:0] rc);
    host_q.push_back({a, hn, rc});
    for (int k = 0; k < 11; k++) sweep_q.push_back({we_tab[k], sval_tab[k]});
    for (int k = 0; k < 8; k++) fill_q.push_back({b, 9'(k)});
    grant_q.push_back({a, b});
  endtask

  task automatic flush_sb();
    host_q.delete(); sweep_q.delete(); fill_q.delete(); grant_q.delete();
    clear_cnt = 0; rise_cnt = 0; hi_len = 0; hs_prev = 1'b0;
    third_rise_cyc = 0; last_rise_cyc = 0; last_fill_cyc = 0; last_ack_cyc = 0; ack_gap = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
    pr_next_angle = 1'b0;
    flush_sb();
    @(negedge clk);
    chk("reset_outputs", out_vec(), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b0;
  endtask

  task automatic pr_request(input string name, input int budget, output int req_cyc);
    bit seen = 1'b0;
    @(posedge clk); #1;
    pr_next_angle = 1'b1;
    req_cyc = cyc;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (pr_next_angle_ack) seen = 1'b1;
    end
    chk(name, 64'(seen), 64'd1);
    @(posedge clk); #1;
    pr_next_angle = 1'b0;
  endtask

  task automatic pr_release_final(input string name);
    @(posedge clk); #1;
    chk({name, "_done_before"}, 64'(done), 64'd0);
    pr_next_angle = 1'b1;
    @(posedge clk); #1;
    pr_next_angle = 1'b0;
    @(negedge clk);
    chk({name, "_done_after"}, 64'(done), 64'd1);
    repeat (3) @(negedge clk);
    chk({name, "_done_sticky"}, 64'(done), 64'd1);
  endtask

  task automatic drain_check(input string name);
    chk({name, "_sweep_left"}, 64'(sweep_q.size()), 64'd0);
    chk({name, "_fill_left"}, 64'(fill_q.size()), 64'd0);
    chk({name, "_grant_left"}, 64'(grant_q.size()), 64'd0);
  endtask

  // Host model: acks the pending request in its req_cycles-th request cycle.
  initial begin
    hs_next_angle_ack = 1'b0;
    hs_angle = '0;
    hs_has_next_angle = 1'b0;
    forever begin
      @(posedge clk); #1;
      hs_next_angle_ack = 1'b0;
      if (!reset_n && hs_next_angle && host_q.size() > 0) begin
        if (host_cnt + 1 >= int'(host_q[0].req_cycles)) begin
          hs_next_angle_ack = 1'b1;
          hs_angle = host_q[0].angle;
          hs_has_next_angle = host_q[0].has_next;
          void'(host_q.pop_front());
          host_cnt = 0;
        end else begin
          host_cnt++;
        end
      end else begin
        host_cnt = 0;
      end
    end
  end

  // Monitor: pops and compares whenever the DUT presents an output.
  always @(negedge clk) begin
    if (!reset_n) begin
      if (filter_enable) begin
        if (sweep_q.size() == 0) fail_unexpected("sweep");
        else begin
          mon_e = sweep_q.pop_front();
          chk("sweep_s_val", 64'(hs_s_val), 64'(mon_e[8:0]));
          chk("sweep_fill_we", 64'(fill_we), 64'(mon_e[9]));
        end
      end else if (fill_we) begin
        fail_unexpected("fill_we_outside_sweep");
      end
      if (fill_we) begin
        last_fill_cyc = cyc;
        if (fill_q.size() == 0) fail_unexpected("fill");
        else begin
          mon_e = fill_q.pop_front();
          chk("fill_bank_addr", 64'({fill_bank, fill_addr}), 64'(mon_e));
        end
      end
      if (pr_next_angle_ack) begin
        last_ack_cyc = cyc;
        ack_gap = cyc - last_fill_cyc;
        if (grant_q.size() == 0) fail_unexpected("grant");
        else begin
          mon_e = grant_q.pop_front();
          chk("grant_angle_bank", 64'({pr_angle, pr_bank}), 64'(mon_e));
        end
      end
      if (filter_clear) clear_cnt++;
      if (hs_next_angle) begin
        chk("req_quiet", 64'({fill_we, filter_clear}), 64'd0);
        if (!hs_prev) begin
          rise_cnt++;
          last_rise_cyc = cyc;
          if (rise_cnt == 3) third_rise_cyc = cyc;
          hi_len = 0;
        end
        hi_len++;
      end
      hs_prev = hs_next_angle;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int rc, release_cyc, t;
    bit found;
    reset_n = 1'b1;
    pr_next_angle = 1'b0;
    sval_tab = '{9'd0, 9'd1, 9'd2, 9'd3, 9'd4, 9'd5, 9'd6, 9'd7, 9'd7, 9'd7, 9'd7};
    we_tab = 11'b111_1111_1000;

    // Single angle, request raised before the fill.
    do_reset();
    push_angle(9'd20, 1'b0, 1'b0, 8'd1);
    pr_request("t1_grant", 200, rc);
    chk("t1_clear_count", 64'(clear_cnt), 64'd1);
    pr_release_final("t1");
    drain_check("t1");

    // Five angles, slow processing side, first request before any fill.
    do_reset();
    push_angle(9'd0,  1'b0, 1'b1, 8'd1);
    push_angle(9'd20, 1'b1, 1'b1, 8'd1);
    push_angle(9'd40, 1'b0, 1'b1, 8'd1);
    push_angle(9'd60, 1'b1, 1'b1, 8'd1);
    push_angle(9'd80, 1'b0, 1'b0, 8'd1);
    pr_request("t2_grant0", 200, rc);
    chk("t2_ack_after_commit", 64'(ack_gap), 64'd2);
    release_cyc = 0;
    for (int i = 1; i < 5; i++) begin
      repeat (50) @(posedge clk);
      pr_request("t2_grant", 200, rc);
      if (i == 1) release_cyc = rc;
    end
    chk("t2_third_req_after_release", 64'(third_rise_cyc > release_cyc), 64'd1);
    chk("t2_clear_count", 64'(clear_cnt), 64'd5);
    repeat (50) @(posedge clk);
    pr_release_final("t2");
    drain_check("t2");

    // Host holds off its ack.
    do_reset();
    push_angle(9'd77, 1'b0, 1'b0, 8'd10);
    pr_request("t3_grant", 300, rc);
    chk("t3_req_len", 64'(hi_len), 64'd10);
    chk("t3_clear_count", 64'(clear_cnt), 64'd1);
    pr_release_final("t3");
    drain_check("t3");

    // Reset in the middle of a sweep.
    do_reset();
    push_angle(9'd33, 1'b0, 1'b1, 8'd1);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (filter_enable && hs_s_val == 9'd4) found = 1'b1;
    end
    chk("t4_reach_k4", 64'(found), 64'd1);
    #1 reset_n = 1'b1;
    #1 chk("t4_outputs_zero_async", out_vec(), 64'd0);
    flush_sb();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b0;
    push_angle(9'd55, 1'b0, 1'b0, 8'd1);
    pr_request("t4_grant", 200, rc);
    chk("t4_single_req", 64'(rise_cnt), 64'd1);
    pr_release_final("t4");
    drain_check("t4");

    // Release arrives in the COMMIT cycle of the other bank.
    do_reset();
    push_angle(9'd11, 1'b0, 1'b1, 8'd1);
    push_angle(9'd22, 1'b1, 1'b1, 8'd1);
    push_angle(9'd99, 1'b0, 1'b0, 8'd1);
    pr_request("t5_grant_a", 200, rc);
    found = 1'b0;
    t = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (fill_we && fill_bank && fill_addr == 9'd7) begin
        found = 1'b1;
        t = cyc;
      end
    end
    chk("t5_reach_b_end", 64'(found), 64'd1);
    pr_request("t5_grant_b", 20, rc);
    repeat (2) @(negedge clk);
    chk("t5_release_in_commit", 64'(rc), 64'(t + 1));
    chk("t5_grant_after_commit", 64'(last_ack_cyc), 64'(t + 2));
    chk("t5_idle_to_req", 64'(last_rise_cyc), 64'(t + 3));
    pr_request("t5_grant_c", 200, rc);
    pr_release_final("t5");
    drain_check("t5");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nabp_filtered_ram_fill_scheduler.md
Name: nabp_filtered_ram_fill_scheduler

Overview:
- Sequences filling of the double-buffered filtered projection RAM, one angle per bank.
- Per angle: requests the angle from the host, clears the filter, sweeps host s-addresses, and writes filter output into the free bank, compensating for lookup and filter latency.
- Hands completed banks to the processing side through the pr_next_angle handshake, in fill order.
- Sits between the host RAM/filter and the filtered RAM swap datapath.

Parameters:
- ANGLE_W, 9, angle bus width.
- S_W, 9, s-address width.
- LINE_SIZE, 256, samples per projection line.
- FILTER_DELAY, 4, filter pipeline depth (filter order / 2).
- LOOKUP_LAT, 1, host RAM read latency in cycles.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset; asynchronous, active-high.
- hs_angle  in  ANGLE_W  host angle; valid while hs_next_angle_ack=1.
- hs_has_next_angle  in  1  host has angles after this one; sampled with ack.
- hs_next_angle_ack  in  1  host acknowledges angle request.
- hs_next_angle  out  1  request next angle from host.
- hs_s_val  out  S_W  host RAM lookup address.
- filter_clear  out  1  clear filter state.
- filter_enable  out  1  advance filter.
- fill_we  out  1  filtered RAM write enable.
- fill_bank  out  1  bank being written.
- fill_addr  out  S_W  filtered RAM write address.
- pr_next_angle  in  1  processing releases current bank and wants the next.
- pr_next_angle_ack  out  1  one-cycle pulse: new bank granted.
- pr_angle  out  ANGLE_W  angle of granted bank; held until next grant.
- pr_bank  out  1  granted bank index.
- done  out  1  all angles filled and consumed.

Behaviour:
- Reset values:
  - All outputs 0.
  - Both banks EMPTY, fill target bank 0, fill FSM IDLE.
- Reset mid-operation aborts the sweep immediately. No further fill_we is issued. Bank states are lost.
- Bank state per bank: EMPTY -> FILLING -> FULL -> IN_USE -> EMPTY.
- Fill FSM:
  - IDLE: if target bank EMPTY and not last_seen, go to REQ.
  - REQ: hs_next_angle=1 until hs_next_angle_ack=1. In the ack cycle, latch hs_angle into the bank angle register and latch last_seen=~hs_has_next_angle. Next cycle: hs_next_angle=0, go to CLEAR.
  - CLEAR: one cycle with filter_clear=1, counter k=0, target bank FILLING.
  - SWEEP: lasts LINE_SIZE+LAT cycles, where LAT=LOOKUP_LAT+FILTER_DELAY.
    - hs_s_val = min(k, LINE_SIZE-1).
    - filter_enable=1.
    - fill_we=1 when LAT <= k < LINE_SIZE+LAT.
    - fill_addr = k-LAT.
    - fill_bank = target.
    - Counter k runs 0..LINE_SIZE+LAT-1, then go to COMMIT.
  - COMMIT: one cycle. Target bank becomes FULL, target toggles, go to IDLE.
- Processing grant:
  - On a pr_next_angle=1 cycle with no grant pending, any IN_USE bank becomes EMPTY.
  - If the oldest FULL bank exists (the one not most recently committed when both are FULL), it becomes IN_USE in the same cycle. pr_next_angle_ack pulses for 1 cycle, and pr_angle/pr_bank update in that cycle.
  - If no FULL bank exists, the request stays pending; the grant fires in the cycle after the COMMIT that fills a bank.
  - pr_next_angle must deassert after ack; level-held request without ack is legal.
  - Each release+grant pair is counted once per rising request.
- Simultaneous events:
  - COMMIT and release in the same cycle are both applied.
  - A bank released in cycle t is fillable by IDLE at t+1.
- done=1 when last_seen is set, the fill FSM is IDLE, no bank is FULL, and pr_next_angle=1 has released the final bank. done is sticky until reset.
- Widths:
  - LINE_SIZE+LAT must fit in S_W+1 bits; the counter is S_W+1 bits wide.
  - No arithmetic wrap is permitted.

Decomposition:
- Package nabp_filtered_ram_pkg:
  - bank_state_t enum {EMPTY, FILLING, FULL, IN_USE}.
  - fill_state_t enum {IDLE, REQ, CLEAR, SWEEP, COMMIT}.
  - Function computing LAT.
- Sub-module nabp_fill_sweep_counter:
  - Inputs: start.
  - Outputs: k-derived hs_s_val, fill_we, fill_addr, last.

Test Plan:
- Use LINE_SIZE=8, FILTER_DELAY=2, LOOKUP_LAT=1 (LAT=3) for all scenarios.
- Single angle, hs_angle=20, has_next=0:
  - filter_clear pulses once.
  - hs_s_val reads 0..7 then 7,7,7.
  - fill_we high for 8 cycles beginning 3 cycles after the sweep starts, fill_addr 0..7, bank 0.
  - Grant gives pr_angle=20, pr_bank=0. The following request sets done=1.
- Angles 0,20,40,60,80 with the processing side slow (request 50 cycles after each grant):
  - Banks alternate 0,1,0,1,0.
  - pr_angle order is 0,20,40,60,80.
  - The third hs_next_angle is not raised before the first release.
- Processing requests before any fill: ack is withheld until COMMIT, then pulses the next cycle with pr_angle=0.
- Host delays ack by 10 cycles: hs_next_angle stays 1 for 10 cycles; no fill_we or filter_clear occurs meanwhile.
- Reset asserted mid-SWEEP at k=4: all outputs are 0 at once. After release, the first fill targets bank 0 and restarts the REQ handshake.
- Release and COMMIT in the same cycle: both bank states update. The next IDLE->REQ occurs the following cycle.
